// File: rtl/ss_tos_stack.sv
// Forth stack with TOS/NOS cached in registers and deeper items in a single-port sync-read RAM.
// Multi-cycle ops (POP refill, deep PICK) drop rdy for one cycle while the RAM read lands.
module ss_tos_stack #(
  parameter int DEPTH = 64,
  parameter int DSZ = 32,
  localparam int SSZ = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [2:0]     op,
  input  logic [DSZ-1:0] vi,
  input  logic [SSZ-1:0] idx,
  output logic           rdy,
  output logic [DSZ-1:0] tos,
  output logic [DSZ-1:0] s0,
  output logic [SSZ:0]   depth,
  output logic           empty,
  output logic           full,
  output logic           ovf,
  output logic           unf
);

  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_LOAD  = 3'd3;
  localparam logic [2:0] OP_PICK  = 3'd4;
  localparam logic [2:0] OP_SWAP  = 3'd5;
  localparam logic [2:0] OP_CLEAR = 3'd6;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REFILL  = 2'd1;
  localparam logic [1:0] ST_PICK_RD = 2'd2;

  localparam logic [SSZ:0] D_ZERO  = (SSZ+1)'(0);
  localparam logic [SSZ:0] D_ONE   = (SSZ+1)'(1);
  localparam logic [SSZ:0] D_TWO   = (SSZ+1)'(2);
  localparam logic [SSZ:0] D_THREE = (SSZ+1)'(3);
  localparam logic [SSZ:0] D_FULL  = (SSZ+1)'(DEPTH);

  logic [DSZ-1:0] mem_r [0:DEPTH-2];
  logic [DSZ-1:0] rdata_r;

  logic [DSZ-1:0] tos_r, s0_r;
  logic [SSZ:0]   depth_r;
  logic           rdy_r, ovf_r, unf_r;
  logic [1:0]     st_r;

  logic [DSZ-1:0] tos_s, s0_s, mem_wdata_s;
  logic [SSZ:0]   depth_s, idx_ext_s;
  logic           rdy_s, ovf_s, unf_s, mem_we_s, mem_re_s;
  logic [1:0]     st_s;
  logic [SSZ-1:0] mem_addr_s;

  assign idx_ext_s = {1'b0, idx};

  // Next-state decode: op acceptance in IDLE, completion of the RAM-read states
  always_comb begin
    tos_s       = tos_r;
    s0_s        = s0_r;
    depth_s     = depth_r;
    ovf_s       = ovf_r;
    unf_s       = unf_r;
    st_s        = st_r;
    mem_we_s    = 1'b0;
    mem_re_s    = 1'b0;
    mem_addr_s  = SSZ'(0);
    mem_wdata_s = tos_r;
    case (st_r)
      ST_IDLE: begin
        case (op)
          OP_PUSH: begin
            if (depth_r == D_FULL) begin
              ovf_s = 1'b1;
            end else begin
              if (depth_r != D_ZERO) begin
                mem_we_s   = 1'b1;
                mem_addr_s = SSZ'(depth_r - D_ONE);
                s0_s       = tos_r;
              end else begin
                s0_s = '0;
              end
              tos_s   = vi;
              depth_s = depth_r + D_ONE;
            end
          end
          OP_POP: begin
            if (depth_r == D_ZERO) begin
              unf_s = 1'b1;
            end else begin
              tos_s   = s0_r;
              depth_s = depth_r - D_ONE;
              if (depth_r >= D_THREE) begin
                mem_re_s   = 1'b1;
                mem_addr_s = SSZ'(depth_r - D_THREE);
                st_s       = ST_REFILL;
              end else begin
                s0_s = '0;
              end
            end
          end
          OP_LOAD: begin
            tos_s = vi;
            if (depth_r == D_ZERO) begin
              depth_s = D_ONE;
            end else begin
              depth_s = depth_r;
            end
          end
          OP_PICK: begin
            // Bad index is reported ahead of overflow
            if (idx_ext_s >= depth_r) begin
              unf_s = 1'b1;
            end else if (depth_r == D_FULL) begin
              ovf_s = 1'b1;
            end else if (idx_ext_s < D_TWO) begin
              mem_we_s   = 1'b1;
              mem_addr_s = SSZ'(depth_r - D_ONE);
              s0_s       = tos_r;
              tos_s      = (idx_ext_s == D_ZERO) ? tos_r : s0_r;
              depth_s    = depth_r + D_ONE;
            end else begin
              mem_re_s   = 1'b1;
              mem_addr_s = SSZ'(depth_r - D_ONE - idx_ext_s);
              st_s       = ST_PICK_RD;
            end
          end
          OP_SWAP: begin
            if (depth_r < D_TWO) begin
              unf_s = 1'b1;
            end else begin
              tos_s      = s0_r;
              s0_s       = tos_r;
              mem_we_s   = 1'b1;
              mem_addr_s = SSZ'(depth_r - D_TWO);
            end
          end
          OP_CLEAR: begin
            depth_s = D_ZERO;
            tos_s   = '1;
            s0_s    = '0;
            ovf_s   = 1'b0;
            unf_s   = 1'b0;
          end
          default: begin
            st_s = ST_IDLE;
          end
        endcase
      end
      ST_REFILL: begin
        s0_s = rdata_r;
        st_s = ST_IDLE;
      end
      ST_PICK_RD: begin
        mem_we_s   = 1'b1;
        mem_addr_s = SSZ'(depth_r - D_ONE);
        s0_s       = tos_r;
        tos_s      = rdata_r;
        depth_s    = depth_r + D_ONE;
        st_s       = ST_IDLE;
      end
      default: begin
        st_s = ST_IDLE;
      end
    endcase
    rdy_s = (st_s == ST_IDLE);
  end

  // Stack registers and control FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tos_r   <= '1;
      s0_r    <= '0;
      depth_r <= D_ZERO;
      rdy_r   <= 1'b1;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
      st_r    <= ST_IDLE;
    end else begin
      tos_r   <= tos_s;
      s0_r    <= s0_s;
      depth_r <= depth_s;
      rdy_r   <= rdy_s;
      ovf_r   <= ovf_s;
      unf_r   <= unf_s;
      st_r    <= st_s;
    end
  end

  // Single-port RAM: a write and a read never share a cycle
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_addr_s] <= mem_wdata_s;
    end else if (mem_re_s) begin
      rdata_r <= mem_r[mem_addr_s];
    end
  end

  assign rdy   = rdy_r;
  assign tos   = tos_r;
  assign s0    = s0_r;
  assign depth = depth_r;
  assign ovf   = ovf_r;
  assign unf   = unf_r;
  assign empty = (depth_r == D_ZERO);
  assign full  = (depth_r == D_FULL);

endmodule

// File: tb/tb_ss_tos_stack.sv
// Directed bench for ss_tos_stack: driver queues hand-computed results, a monitor
// compares them once each accepted op completes (rdy back high).
module tb_ss_tos_stack;

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, LOAD = 3'd3,
                         PICK = 3'd4, SWAP = 3'd5, CLR = 3'd6;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] vi = 32'd0;
  logic [5:0]  idx = 6'd0;
  logic        rdy, empty, full, ovf, unf;
  logic [31:0] tos, s0;
  logic [6:0]  depth;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] t;
    logic [31:0] s;
    int          d;
    logic        o;
    logic        u;
    int          l;
  } exp_t;
  exp_t exp_q[$];

  ss_tos_stack #(.DEPTH(64), .DSZ(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .vi(vi), .idx(idx), .rdy(rdy),
    .tos(tos), .s0(s0), .depth(depth), .empty(empty), .full(full),
    .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  // Monitor: detect acceptance, wait for completion, compare against the queue head
  initial begin : monitor
    exp_t e;
    int lat;
    forever begin
      @(posedge clk);
      if (rst_n && rdy && op != NOP && op != 3'b111) begin
        lat = 0;
        do begin
          @(negedge clk);
          lat++;
        end while (!rdy && lat < 6);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: op %0d accepted with no expected entry", op);
        end else begin
          e = exp_q.pop_front();
          if (tos !== e.t || s0 !== e.s || int'(depth) != e.d || ovf !== e.o ||
              unf !== e.u || empty !== (e.d == 0) || full !== (e.d == 64) || lat != e.l) begin
            errors++;
            $display("FAIL op_result: got tos=%h s0=%h d=%0d ovf=%b unf=%b emp=%b full=%b lat=%0d; want tos=%h s0=%h d=%0d ovf=%b unf=%b lat=%0d",
                     tos, s0, depth, ovf, unf, empty, full, lat, e.t, e.s, e.d, e.o, e.u, e.l);
          end
        end
      end
    end
  end

  task automatic do_op(input logic [2:0] o, input logic [31:0] v, input logic [5:0] ix,
                       input logic [31:0] et, input logic [31:0] es, input int ed,
                       input logic eo, input logic eu, input int el, input bit mid_rst);
    int n;
    exp_q.push_back('{t: et, s: es, d: ed, o: eo, u: eu, l: el});
    @(negedge clk);
    op = o; vi = v; idx = ix;
    n = 0;
    while (!rdy && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) begin
      errors++;
      $display("FAIL rdy_timeout: rdy=%b after %0d cycles, want 1", rdy, n);
    end
    @(posedge clk);
    #1;
    op = NOP;
    if (mid_rst) begin
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  task automatic check_reset(input string name);
    @(negedge clk);
    checks++;
    if (tos !== ONES || s0 !== 32'd0 || depth !== 7'd0 || rdy !== 1'b1 ||
        ovf !== 1'b0 || unf !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL %s: got tos=%h s0=%h d=%0d rdy=%b ovf=%b unf=%b emp=%b full=%b; want tos=ffffffff s0=0 d=0 rdy=1 flags=0 emp=1 full=0",
               name, tos, s0, depth, rdy, ovf, unf, empty, full);
    end
  endtask

  initial begin : driver
    int w;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_reset("reset_state");

    // 1: pushes
    do_op(PUSH, 32'd1, 6'd0, 32'd1, 32'd0, 1, 1'b0, 1'b0, 1, 1'b0);
    do_op(PUSH, 32'd2, 6'd0, 32'd2, 32'd1, 2, 1'b0, 1'b0, 1, 1'b0);
    do_op(PUSH, 32'd3, 6'd0, 32'd3, 32'd2, 3, 1'b0, 1'b0, 1, 1'b0);

    // 2: pops with refill; a PUSH presented while rdy=0 must be ignored
    do_op(POP, 32'd0, 6'd0, 32'd2, 32'd1, 2, 1'b0, 1'b0, 2, 1'b0);
    op = PUSH; vi = 32'd99;
    @(posedge clk);
    #1;
    op = NOP;
    do_op(POP, 32'd0, 6'd0, 32'd1, 32'd0, 1, 1'b0, 1'b0, 1, 1'b0);
    do_op(POP, 32'd0, 6'd0, 32'd0, 32'd0, 0, 1'b0, 1'b0, 1, 1'b0);
    do_op(POP, 32'd0, 6'd0, 32'd0, 32'd0, 0, 1'b0, 1'b1, 1, 1'b0);
    do_op(CLR, 32'd0, 6'd0, ONES, 32'd0, 0, 1'b0, 1'b0, 1, 1'b0);

    // 3: PICK deep, bad index, OVER, DUP, then pops read back the copies
    for (int i = 0; i < 5; i++)
      do_op(PUSH, 32'(10 + i), 6'd0, 32'(10 + i), (i == 0) ? 32'd0 : 32'(9 + i), i + 1,
            1'b0, 1'b0, 1, 1'b0);
    do_op(PICK, 32'd0, 6'd3, 32'd11, 32'd14, 6, 1'b0, 1'b0, 2, 1'b0);
    do_op(PICK, 32'd0, 6'd6, 32'd11, 32'd14, 6, 1'b0, 1'b1, 1, 1'b0);
    do_op(PICK, 32'd0, 6'd1, 32'd14, 32'd11, 7, 1'b0, 1'b1, 1, 1'b0);
    do_op(PICK, 32'd0, 6'd0, 32'd14, 32'd14, 8, 1'b0, 1'b1, 1, 1'b0);
    do_op(POP, 32'd0, 6'd0, 32'd14, 32'd11, 7, 1'b0, 1'b1, 2, 1'b0);
    do_op(POP, 32'd0, 6'd0, 32'd11, 32'd14, 6, 1'b0, 1'b1, 2, 1'b0);
    do_op(CLR, 32'd0, 6'd0, ONES, 32'd0, 0, 1'b0, 1'b0, 1, 1'b0);

    // 4: fill to capacity, overflow, pop from full, clear
    for (int i = 0; i < 64; i++)
      do_op(PUSH, 32'(i + 1), 6'd0, 32'(i + 1), 32'(i), i + 1, 1'b0, 1'b0, 1, 1'b0);
    do_op(PUSH, 32'hDEAD, 6'd0, 32'd64, 32'd63, 64, 1'b1, 1'b0, 1, 1'b0);
    do_op(PICK, 32'd0, 6'd0, 32'd64, 32'd63, 64, 1'b1, 1'b0, 1, 1'b0);
    do_op(POP, 32'd0, 6'd0, 32'd63, 32'd62, 63, 1'b1, 1'b0, 2, 1'b0);
    do_op(CLR, 32'd0, 6'd0, ONES, 32'd0, 0, 1'b0, 1'b0, 1, 1'b0);

    // 5: SWAP writes the old tos into RAM, visible after a later refill
    do_op(PUSH, 32'd7, 6'd0, 32'd7, 32'd0, 1, 1'b0, 1'b0, 1, 1'b0);
    do_op(PUSH, 32'd8, 6'd0, 32'd8, 32'd7, 2, 1'b0, 1'b0, 1, 1'b0);
    do_op(SWAP, 32'd0, 6'd0, 32'd7, 32'd8, 2, 1'b0, 1'b0, 1, 1'b0);
    do_op(PUSH, 32'd9, 6'd0, 32'd9, 32'd7, 3, 1'b0, 1'b0, 1, 1'b0);
    do_op(POP, 32'd0, 6'd0, 32'd7, 32'd8, 2, 1'b0, 1'b0, 2, 1'b0);
    do_op(POP, 32'd0, 6'd0, 32'd8, 32'd0, 1, 1'b0, 1'b0, 1, 1'b0);
    do_op(POP, 32'd0, 6'd0, 32'd0, 32'd0, 0, 1'b0, 1'b0, 1, 1'b0);
    do_op(LOAD, 32'd5, 6'd0, 32'd5, 32'd0, 1, 1'b0, 1'b0, 1, 1'b0);
    do_op(LOAD, 32'd6, 6'd0, 32'd6, 32'd0, 1, 1'b0, 1'b0, 1, 1'b0);
    do_op(SWAP, 32'd0, 6'd0, 32'd6, 32'd0, 1, 1'b0, 1'b1, 1, 1'b0);
    do_op(CLR, 32'd0, 6'd0, ONES, 32'd0, 0, 1'b0, 1'b0, 1, 1'b0);

    // 6: reset asserted during REFILL and during PICK_RD
    do_op(PUSH, 32'd1, 6'd0, 32'd1, 32'd0, 1, 1'b0, 1'b0, 1, 1'b0);
    do_op(PUSH, 32'd2, 6'd0, 32'd2, 32'd1, 2, 1'b0, 1'b0, 1, 1'b0);
    do_op(PUSH, 32'd3, 6'd0, 32'd3, 32'd2, 3, 1'b0, 1'b0, 1, 1'b0);
    do_op(POP, 32'd0, 6'd0, ONES, 32'd0, 0, 1'b0, 1'b0, 1, 1'b1);
    check_reset("reset_in_refill");
    do_op(PUSH, 32'd10, 6'd0, 32'd10, 32'd0, 1, 1'b0, 1'b0, 1, 1'b0);
    do_op(PUSH, 32'd20, 6'd0, 32'd20, 32'd10, 2, 1'b0, 1'b0, 1, 1'b0);
    do_op(PUSH, 32'd30, 6'd0, 32'd30, 32'd20, 3, 1'b0, 1'b0, 1, 1'b0);
    do_op(PICK, 32'd0, 6'd2, ONES, 32'd0, 0, 1'b0, 1'b0, 1, 1'b1);
    check_reset("reset_in_pick_rd");
    do_op(PUSH, 32'd4, 6'd0, 32'd4, 32'd0, 1, 1'b0, 1'b0, 1, 1'b0);

    w = 0;
    while (exp_q.size() != 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected results never observed, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
